// File: rtl/package_settings.sv
// Shared widths for the ADC channel chain.
//   SIZE_FILTER_DATA : width of the signed trapezoidal shaper output
//   SIZE_TIMESTAMP   : width of the free-running sample timestamp
package package_settings;
  localparam int SIZE_FILTER_DATA = 16;
  localparam int SIZE_TIMESTAMP   = 32;
endpackage

// File: rtl/peak_finder_params.sv
// Types and default constants for trap_peak_finder.
//   peak_state_t        : detector FSM states
//   DEFAULT_HYSTERESIS  : disarm offset below threshold
//   DEFAULT_HOLDOFF     : dead cycles after a pulse
//   DEFAULT_MAX_WIDTH   : pile-up width limit
//   sat_inc8()          : saturating 8-bit increment
package peak_finder_params;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RISE   = 2'd1,
    ST_REJECT = 2'd2,
    ST_HOLD   = 2'd3
  } peak_state_t;

  localparam int DEFAULT_HYSTERESIS = 16;
  localparam int DEFAULT_HOLDOFF    = 8;
  localparam int DEFAULT_MAX_WIDTH  = 64;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/peak_out_reg.sv
// Single-entry valid/ready holding register for peak event records.
// A new event loads when the register is empty or is being accepted on the
// same edge; otherwise it is dropped and lost_count (saturating) increments.
// Ports:
//   clk, reset (async, active-low)
//   load, load_amplitude, load_time, load_width : event from the detector
//   peak_ready                                  : consumer accepts record
//   peak_valid, peak_amplitude, peak_time, peak_width : held record
//   lost_count                                  : dropped-event counter
module peak_out_reg
  import package_settings::*;
(
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               load,
  input  logic signed [SIZE_FILTER_DATA-1:0] load_amplitude,
  input  logic        [SIZE_TIMESTAMP-1:0]   load_time,
  input  logic        [7:0]                  load_width,
  input  logic                               peak_ready,
  output logic                               peak_valid,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [SIZE_TIMESTAMP-1:0]   peak_time,
  output logic        [7:0]                  peak_width,
  output logic        [15:0]                 lost_count
);

  logic accept;
  assign accept = peak_valid && peak_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      peak_valid     <= 1'b0;
      peak_amplitude <= '0;
      peak_time      <= '0;
      peak_width     <= '0;
      lost_count     <= '0;
    end else if (load && (!peak_valid || accept)) begin
      peak_valid     <= 1'b1;
      peak_amplitude <= load_amplitude;
      peak_time      <= load_time;
      peak_width     <= load_width;
    end else begin
      if (accept) begin
        peak_valid <= 1'b0;
      end
      // Reaching here with load set means the register is full and not draining.
      if (load && (lost_count != 16'hFFFF)) begin
        lost_count <= lost_count + 16'd1;
      end
    end
  end

endmodule

// File: rtl/trap_peak_finder.sv
// Pulse detector on the trapezoidal shaper output. Arms when a sample exceeds
// threshold, tracks the flat-top maximum, its timestamp and the pulse width,
// and disarms at threshold - HYSTERESIS, emitting one event record over a
// valid/ready handshake. A HOLD period of HOLDOFF cycles follows each pulse.
// Optional feature macro: PEAK_PILEUP_REJECT_EN (width-based pile-up reject).
// Ports:
//   clk, reset (async, active-low)
//   filter_data, threshold, enable   : sample stream and arming controls
//   peak_valid/peak_ready            : event handshake
//   peak_amplitude, peak_time, peak_width : event record
//   lost_count, pileup_count         : saturating statistics
//   busy                             : FSM not IDLE
module trap_peak_finder
  import package_settings::*;
  import peak_finder_params::*;
#(
  parameter int HYSTERESIS = DEFAULT_HYSTERESIS,
  parameter int HOLDOFF    = DEFAULT_HOLDOFF,
  parameter int MAX_WIDTH  = DEFAULT_MAX_WIDTH
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic signed [SIZE_FILTER_DATA-1:0] filter_data,
  input  logic signed [SIZE_FILTER_DATA-1:0] threshold,
  input  logic                               enable,
  output logic                               peak_valid,
  input  logic                               peak_ready,
  output logic signed [SIZE_FILTER_DATA-1:0] peak_amplitude,
  output logic        [SIZE_TIMESTAMP-1:0]   peak_time,
  output logic        [7:0]                  peak_width,
  output logic        [15:0]                 lost_count,
  output logic        [15:0]                 pileup_count,
  output logic                               busy
);

  localparam int W    = SIZE_FILTER_DATA;
  localparam int HC_W = $clog2(HOLDOFF + 2);

  peak_state_t                 state_reg, state_next;
  logic        [SIZE_TIMESTAMP-1:0] timestamp_reg;
  logic signed [W-1:0]         max_reg, max_next;
  logic        [SIZE_TIMESTAMP-1:0] max_time_reg, max_time_next;
  logic        [7:0]           width_reg, width_next;
  logic        [HC_W-1:0]      hold_cnt_reg, hold_cnt_next;
  logic                        emit;

  // Disarm level is one bit wider so a strongly negative threshold cannot wrap
  // to a large positive value and end every pulse on its first sample.
  logic signed [W:0] disarm_level;
  logic signed [W:0] sample_ext;
  logic              above, disarm, hold_done;

  assign disarm_level = $signed({threshold[W-1], threshold}) - $signed((W+1)'(HYSTERESIS));
  assign sample_ext   = $signed({filter_data[W-1], filter_data});
  assign above        = filter_data > threshold;
  assign disarm       = sample_ext <= disarm_level;
  // HOLDOFF of 0 or 1 both give a single HOLD cycle.
  assign hold_done    = (HOLDOFF <= 1) ? 1'b1 : (hold_cnt_reg == HC_W'(HOLDOFF - 1));

`ifdef PEAK_PILEUP_REJECT_EN
  logic       pileup_inc;
  logic [8:0] width_plus;
  logic [15:0] pileup_count_reg;
  assign width_plus = {1'b0, width_reg} + 9'd1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      timestamp_reg <= '0;
      max_reg       <= '0;
      max_time_reg  <= '0;
      width_reg     <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      timestamp_reg <= timestamp_reg + 1'b1;
      max_reg       <= max_next;
      max_time_reg  <= max_time_next;
      width_reg     <= width_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    max_next      = max_reg;
    max_time_next = max_time_reg;
    width_next    = width_reg;
    hold_cnt_next = hold_cnt_reg;
    emit          = 1'b0;
`ifdef PEAK_PILEUP_REJECT_EN
    pileup_inc    = 1'b0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (enable && above) begin
          state_next    = ST_RISE;
          max_next      = filter_data;
          max_time_next = timestamp_reg;
          width_next    = 8'd1;
        end
      end
      ST_RISE: begin
        if (disarm) begin
          // End sample is neither counted nor compared against the maximum.
          state_next    = ST_HOLD;
          hold_cnt_next = '0;
          emit          = 1'b1;
        end else begin
          // Strict compare keeps the earliest sample of a flat top.
          if (filter_data > max_reg) begin
            max_next      = filter_data;
            max_time_next = timestamp_reg;
          end
          width_next = sat_inc8(width_reg);
`ifdef PEAK_PILEUP_REJECT_EN
          if (int'(width_plus) >= MAX_WIDTH) begin
            state_next = ST_REJECT;
            pileup_inc = 1'b1;
          end
`endif
        end
      end
`ifdef PEAK_PILEUP_REJECT_EN
      ST_REJECT: begin
        if (disarm) begin
          state_next    = ST_HOLD;
          hold_cnt_next = '0;
        end
      end
`endif
      ST_HOLD: begin
        if (hold_done) begin
          state_next = ST_IDLE;
        end else begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

`ifdef PEAK_PILEUP_REJECT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pileup_count_reg <= '0;
    end else if (pileup_inc && (pileup_count_reg != 16'hFFFF)) begin
      pileup_count_reg <= pileup_count_reg + 16'd1;
    end
  end
  assign pileup_count = pileup_count_reg;
`else
  assign pileup_count = 16'd0;
`endif

  assign busy = (state_reg != ST_IDLE);

  peak_out_reg u_out (
    .clk            (clk),
    .reset          (reset),
    .load           (emit),
    .load_amplitude (max_reg),
    .load_time      (max_time_reg),
    .load_width     (width_reg),
    .peak_ready     (peak_ready),
    .peak_valid     (peak_valid),
    .peak_amplitude (peak_amplitude),
    .peak_time      (peak_time),
    .peak_width     (peak_width),
    .lost_count     (lost_count)
  );

endmodule
